// File: rtl/mdu_iter.sv
// mdu_iter: shared iterative multiply/divide unit (shift-add multiply, restoring divide).
// Define MDU_MUL_EARLY_OUT_EN to let a multiply finish once no multiplier bits remain.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div0_o,
  output logic               stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 div0_q, div0_d;
  // acc: product accumulator (mul) or partial remainder in the low WIDTH+1 bits (div).
  // sh:  shifting multiplicand (mul) or dividend/quotient shift register in the low WIDTH bits (div).
  // opb: right-shifting multiplier (mul) or divisor magnitude (div).
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]     opb_q, opb_d;

  logic                 in_div, in_neg1, in_neg2;
  logic [2*WIDTH-1:0]   mul_add, prod_nx;
  logic [WIDTH:0]       rem_sh, rem_nx;
  logic                 div_ge;
  logic [WIDTH-1:0]     quo_nx;
  logic                 last_iter, early_out;
  logic [2*WIDTH-1:0]   fin_res;

  assign in_div  = op_i[1];
  assign in_neg1 = ~op_i[0] & opdata1_i[WIDTH-1];
  assign in_neg2 = ~op_i[0] & opdata2_i[WIDTH-1];

  // One iteration of each algorithm, evaluated from the current registers.
  assign mul_add = opb_q[0] ? sh_q : '0;
  assign prod_nx = acc_q + mul_add;
  assign rem_sh  = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
  assign div_ge  = rem_sh >= {1'b0, opb_q};
  assign rem_nx  = div_ge ? (rem_sh - {1'b0, opb_q}) : rem_sh;
  assign quo_nx  = {sh_q[WIDTH-2:0], div_ge};

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MDU_MUL_EARLY_OUT_EN
  assign early_out = ~op_q[1] & ~|opb_q[WIDTH-1:1];
`else
  assign early_out = 1'b0;
`endif

  assign fin_res = op_q[1]
                 ? {cond_neg_w(rem_nx[WIDTH-1:0], neg_rem_q), cond_neg_w(quo_nx, neg_res_q)}
                 : cond_neg_2w(prod_nx, neg_res_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ready_d   = ready_q;
    div0_d    = div0_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    opb_d     = opb_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d      = op_i;
          neg_res_d = in_neg1 ^ in_neg2;
          neg_rem_d = in_neg1;
          cnt_d     = '0;
          acc_d     = '0;
          sh_d      = {{WIDTH{1'b0}}, cond_neg_w(opdata1_i, in_neg1)};
          opb_d     = cond_neg_w(opdata2_i, in_neg2);
          if (in_div && (opdata2_i == '0)) begin
            state_d  = S_DONE;
            result_d = {opdata1_i, {WIDTH{1'b1}}};
            ready_d  = 1'b1;
            div0_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            ready_d = 1'b0;
            div0_d  = 1'b0;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          acc_d = {{(WIDTH-1){1'b0}}, rem_nx};
          sh_d  = {{WIDTH{1'b0}}, quo_nx};
        end else begin
          acc_d = prod_nx;
          sh_d  = sh_q << 1;
          opb_d = opb_q >> 1;
        end
        if (last_iter || early_out) begin
          state_d  = S_DONE;
          result_d = fin_res;
          ready_d  = 1'b1;
          div0_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (!start_i) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
          div0_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        div0_d  = 1'b0;
      end
    endcase

    // Flush wins over everything, including a same-cycle start.
    if (annul_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = '0;
      ready_d  = 1'b0;
      div0_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      div0_q    <= div0_d;
    end
  end

  // Datapath registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    sh_q  <= sh_d;
    opb_q <= opb_d;
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign div0_o     = div0_q;
  assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed bench for mdu_iter against an arithmetic reference model.
// Follows MDU_MUL_EARLY_OUT_EN for the expected multiply latency.
module tb_mdu_iter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn;
  logic           start_i;
  logic [1:0]     op_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           div0_o;
  logic           stallreq_o;

  mdu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start_i),
    .op_i      (op_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .div0_o    (div0_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_res;
  logic        exp_div0;
  int          exp_lat;
  bit          active = 1'b0;
  int          txn_id = 0;
  int          last_id = 0;
  int          cyc = 0;
  bit          seen_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic on 64-bit integers.
  function automatic void ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [63:0] res, output logic d0);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    d0 = 1'b0;
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
          d0  = 1'b1;
        end else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
    if (op[1] && b == 32'd0) return 1;
`ifdef MDU_MUL_EARLY_OUT_EN
    if (!op[1]) begin
      logic [31:0] m;
      int n;
      m = (op == 2'b00 && b[31]) ? -b : b;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return ((n < 1) ? 1 : n) + 1;
    end
`endif
    return W + 1;
  endfunction

  // Single compare process: every falling edge.
  always @(negedge clk) begin
    if (txn_id != last_id) begin
      last_id    = txn_id;
      cyc        = 0;
      seen_ready = 1'b0;
    end
    check("stallreq", 64'(stallreq_o), 64'(start_i & ~ready_o));
    if (active) begin
      if (ready_o) begin
        if (!seen_ready) begin
          check("latency", 64'(cyc), 64'(exp_lat));
          seen_ready = 1'b1;
        end
        check("result", result_o, exp_res);
        check("div0", 64'(div0_o), 64'(exp_div0));
      end
      cyc++;
    end else if (resetn) begin
      check("idle_ready", 64'(ready_o), 64'd0);
    end
  end

  task automatic do_reset();
    resetn  = 1'b0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit drop_start, input bit scramble);
    int n;
    ref_calc(op, a, b, exp_res, exp_div0);
    exp_lat = ref_lat(op, b);
    @(posedge clk);
    #1;
    op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    txn_id++;
    active = 1'b1;
    n = 0;
    while (!seen_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (scramble) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        op_i      = 2'($urandom);
      end
      if (drop_start && n == 3) start_i = 1'b0;
    end
    if (!seen_ready) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no ready_o expected ready within %0d cycles", exp_lat);
      active = 1'b0;
      do_reset();
    end
    start_i = 1'b0;
    n = 0;
    while (ready_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    active = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [63:0] r64;
  logic        d0;

  initial begin
    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    op_i = 2'b00; opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_div0", 64'(div0_o), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Pin the reference model with hand-computed values.
    ref_calc(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, r64, d0);
    check("model_mult", r64, 64'hFFFF_FFFF_FFFF_FFFA);
    ref_calc(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r64, d0);
    check("model_multu", r64, 64'hFFFF_FFFE_0000_0001);
    ref_calc(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, r64, d0);
    check("model_div", r64, 64'hFFFF_FFFF_FFFF_FFFD);
    ref_calc(2'b11, 32'd7, 32'd2, r64, d0);
    check("model_divu", r64, 64'h0000_0001_0000_0003);
    ref_calc(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r64, d0);
    check("model_minneg1", {r64[63:1], d0}, 64'h0000_0000_8000_0000);
    ref_calc(2'b11, 32'd5, 32'd0, r64, d0);
    check("model_div0", r64, 64'h0000_0005_FFFF_FFFF);
    check("model_div0_flag", 64'(d0), 64'd1);
    check("model_lat_div0", 64'(ref_lat(2'b11, 32'd0)), 64'd1);
`ifdef MDU_MUL_EARLY_OUT_EN
    check("model_lat_x1", 64'(ref_lat(2'b01, 32'd1)), 64'd2);
`else
    check("model_lat_x1", 64'(ref_lat(2'b01, 32'd1)), 64'd33);
`endif

    // Directed vectors.
    run_txn(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0);
    run_txn(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_txn(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    run_txn(2'b11, 32'd7, 32'd2, 1'b0, 1'b1);
    run_txn(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_txn(2'b11, 32'd5, 32'd0, 1'b0, 1'b0);
    run_txn(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    run_txn(2'b01, 32'h1234_5678, 32'd1, 1'b0, 1'b0);

    // Flush a divide in cycle 10; previous result is nonzero so the clear is visible.
    @(posedge clk);
    #1;
    op_i = 2'b10; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    check("annul_div0", 64'(div0_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    run_txn(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk);
    #1;
    op_i = 2'b01; opdata1_i = 32'h0F0F_0F0F; opdata2_i = 32'hFFFF_FFFF; start_i = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_ready", 64'(ready_o), 64'd0);
    check("arst_result", result_o, 64'd0);
    check("arst_div0", 64'(div0_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
    run_txn(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      run_txn(2'($urandom), pick(), pick(), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit for the EX stage. It replaces the separate multiplier and divider instances with one shared datapath. Signed and unsigned multiply and divide are selected by a 2-bit op code, with operand width set by a parameter. The start/ready/annul handshake stays as before; the block adds a direct stall output, a divide-by-zero flag, and an optional multiply early-out.

## Interface
- WIDTH, 32: operand width in bits; result is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_i  in  1  request; held high by EX until ready_o is seen.
- op_i  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- opdata1_i  in  WIDTH  multiplicand or dividend.
- opdata2_i  in  WIDTH  multiplier or divisor.
- annul_i  in  1  abort the current operation (flush).
- result_o  out  2*WIDTH  result:
  - mul: full product {hi,lo}.
  - div: {remainder, quotient}.
- ready_o  out  1  result_o is valid.
- div0_o  out  1  the completed division had a zero divisor; valid with ready_o.
- stallreq_o  out  1  = start_i & ~ready_o (combinational).

## Operation
- States: IDLE, CALC, DONE. Operands, op_i and sign flags are latched only on the IDLE→CALC or IDLE→DONE edge. Input changes after that edge are ignored.
- IDLE:
  - start_i=1 with a div op and opdata2_i=0 → DONE directly. Quotient = all ones; remainder = dividend as given; div0_o=1.
  - start_i=1 otherwise → CALC. Load operand magnitudes; counter=0.
- Signed ops (mult, div): operands are converted to magnitudes. After the final iteration:
  - product is negated if the sign bits differ;
  - quotient is negated if the sign bits differ;
  - remainder takes the dividend's sign.
- Multiply in CALC: shift-add, one multiplier bit per cycle, WIDTH iterations.
- Divide in CALC: restoring, one quotient bit per cycle, WIDTH iterations.
- When the counter reaches WIDTH-1, the sign-corrected result is registered into result_o and the FSM enters DONE.
- DONE: ready_o=1; result_o and div0_o are held. The FSM returns to IDLE on the first cycle start_i=0.
- Signed MIN / -1 wraps: quotient = MIN, remainder = 0, div0_o=0.
- annul_i=1 in any state → IDLE next edge. Clears ready_o, div0_o and result_o to 0. annul_i has priority over start_i in the same cycle.
- resetn=0, including mid-operation, immediately forces IDLE with ready_o=0, div0_o=0, result_o=0 and counter=0.

## Timing
- Reset values: result_o=0, ready_o=0, div0_o=0. stallreq_o follows start_i.
- Normal latency: start_i rises in cycle 0 → CALC in cycles 1..WIDTH → ready_o=1 from cycle WIDTH+1. That is 33 cycles at WIDTH=32.
- Divide by zero: ready_o=1 in cycle 1.
- stallreq_o is high from cycle 0 until the cycle ready_o=1. EX sees the result and drops start_i in the same cycle.
- Back-to-back requests: after DONE, one IDLE cycle with start_i=0 is required before the next start_i is sampled.
- start_i dropping during CALC (without annul_i) does not abort; the result is held in DONE until the following IDLE return.

## Configuration
- MDU_MUL_EARLY_OUT_EN defined:
  - In CALC for a multiply, if the remaining unshifted multiplier bits are all zero, the FSM finishes on that cycle: result is finalised and registered, then DONE.
  - Minimum multiply latency is 2 cycles (multiplier 0 or 1 after magnitude). Divide is unaffected.
- Not defined: every multiply takes exactly WIDTH CALC cycles. Latency is fixed as in Timing.

## Test plan
- mult, WIDTH=32: 0xFFFFFFFE × 0x00000003 → result_o=0xFFFFFFFF_FFFFFFFA; ready_o in cycle 33; stallreq_o high cycles 0–32.
- multu: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001.
- div: 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- divu 7/2 → {1, 3}.
- div 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}, div0_o=0.
- divu 5/0 → ready_o in cycle 1; {0x00000005, 0xFFFFFFFF}; div0_o=1.
- Flush and reset:
  - annul_i in cycle 10 of a div → ready_o stays 0, result_o=0, IDLE in cycle 11.
  - A new multu started after that is correct.
  - resetn pulsed low mid-multiply → all outputs 0 asynchronously.
- With MDU_MUL_EARLY_OUT_EN: multu 0x12345678 × 1 → 0x00000000_12345678 with ready_o in cycle 2.
- Without MDU_MUL_EARLY_OUT_EN: the same multu 0x12345678 × 1 → ready_o in cycle 33.
